tx_pcs_sequencer: RTL and testbench
===================================

# tx_pcs_sequencer

Sequencer for the 10GBASE-R transmit path ahead of the self-synchronous scrambler and the 64b/66b gearbox. Brings the path out of reset, drives the scrambler's init-done and pause controls, and runs the 33-cycle gearbox pause cadence. Accepts 66-bit blocks from the MAC-side encoder under a valid/ready handshake and inserts idle control blocks whenever the encoder has nothing to send. Sits between the encoder and the scrambler/gearbox in the TX clock domain.

## Interface
- SEQ_MAX, 32: gearbox sequence terminal count; one pause cycle per SEQ_MAX+1 cycles.
- INIT_CYCLES, 64: consecutive cycles of i_phy_ready required before the path is declared initialised (≥1).
- i_txc  in  1  TX clock; the only clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_phy_ready  in  1  PMA/gearbox ready, synchronous to i_txc.
- i_tx_valid  in  1  encoder block valid.
- i_txd  in  64  encoder block payload.
- i_txh  in  2  encoder sync header (2'b01 data, 2'b10 control).
- o_tx_ready  out  1  block accepted this cycle when high with i_tx_valid.
- o_txd  out  64  payload to scrambler.
- o_txh  out  2  header to gearbox.
- o_init_done  out  1  to scrambler init-done input.
- o_tx_pause  out  1  to scrambler and gearbox pause inputs.
- o_gearbox_seq  out  6  current gearbox sequence, 0..SEQ_MAX.
- o_idle_inserted  out  1  one-cycle pulse: an idle block was generated this cycle.

## Operation
- Idle block: o_txh=2'b10, o_txd=64'h0000_0000_0000_001E (block type 0x1E, eight /I/ codes 0x00).
- States: WAIT, INIT, RUN.
  - WAIT: all counters 0. i_phy_ready=1 → INIT.
  - INIT: init_cnt increments each cycle with i_phy_ready=1. i_phy_ready=0 → WAIT. init_cnt reaching INIT_CYCLES-1 with i_phy_ready=1 → RUN.
  - RUN: o_init_done=1. i_phy_ready=0 → WAIT (abandons any block in flight; no partial handling).
- Sequence counter (RUN only): increments every cycle, wraps SEQ_MAX→0. Cleared to 0 on entry to RUN and in WAIT/INIT.
- Pause: pause cycle is seq==SEQ_MAX. o_tx_ready combinational = (state==RUN) && (seq!=SEQ_MAX).
- Accept: i_tx_valid && o_tx_ready → register i_txd/i_txh to outputs. Ready && !valid → register idle block, pulse o_idle_inserted. Pause cycle → outputs hold.
- i_txh of 2'b00 or 2'b11 on accept: replaced by the idle block; o_idle_inserted pulses.
- Outside RUN: o_txd/o_txh forced to the idle block, o_tx_ready=0, o_idle_inserted=0.

## Timing
- Reset values: o_txd=64'h1E, o_txh=2'b10, o_init_done=0, o_tx_pause=0, o_gearbox_seq=0, o_tx_ready=0, o_idle_inserted=0; state WAIT.
- Reset is asserted asynchronously. Release is synchronous to i_txc; the first transition out of WAIT is possible on the first edge after release.
- Latency: accepted block appears on o_txd/o_txh one cycle after the accepting edge.
- o_tx_pause is registered: high exactly in the cycle after seq==SEQ_MAX was presented. That cycle is aligned with the held o_txd, so the scrambler sees pause together with the repeated data.
- o_gearbox_seq is registered alongside o_txd, so both describe the same block.
- o_init_done rises on the first edge of RUN. First data/idle output follows one cycle later.
- Entry from INIT to RUN requires exactly INIT_CYCLES consecutive ready cycles; an interruption restarts the count from 0 via WAIT.
- Falling i_phy_ready in RUN: next edge gives o_init_done=0, o_tx_pause=0, seq=0, and idle outputs.
- Simultaneous valid and pause cycle: pause wins, no accept, encoder holds its block.

## Test plan
- Reset, then i_phy_ready=1 held → o_init_done rises after exactly 64 cycles; o_tx_ready high the same cycle; before that, outputs stay at the idle block.
- RUN with i_tx_valid=1 and an incrementing i_txd → o_tx_ready low exactly once per 33 cycles (seq 32). o_tx_pause high the next cycle with o_txd repeated. No block is lost or duplicated over 330 cycles.
- RUN with i_tx_valid=0 → o_txd=64'h1E and o_txh=2'b10 every non-pause cycle; o_idle_inserted pulses 32 of every 33 cycles.
- i_phy_ready dropped at init_cnt=40, restored → o_init_done rises 64 cycles after restore, not 24.
- i_phy_ready dropped in RUN at seq=17 → next cycle o_init_done=0, seq=0, idle outputs. After 64 ready cycles, RUN resumes with seq starting at 0.
- i_reset_n asserted mid-RUN between edges → all outputs take their reset values immediately, before the next i_txc edge. An accept with i_txh=2'b11 → idle block emitted and o_idle_inserted=1.

Source files
------------

// File: rtl/tx_pcs_sequencer.sv
// 10GBASE-R TX sequencer: brings the path out of reset, drives the scrambler
// init-done/pause controls, runs the gearbox pause cadence and inserts idle
// control blocks whenever the encoder has nothing valid to send.
module tx_pcs_sequencer #(
  parameter int unsigned SEQ_MAX     = 32,
  parameter int unsigned INIT_CYCLES = 64
) (
  input  logic        i_txc,
  input  logic        i_reset_n,
  input  logic        i_phy_ready,
  input  logic        i_tx_valid,
  input  logic [63:0] i_txd,
  input  logic [1:0]  i_txh,
  output logic        o_tx_ready,
  output logic [63:0] o_txd,
  output logic [1:0]  o_txh,
  output logic        o_init_done,
  output logic        o_tx_pause,
  output logic [5:0]  o_gearbox_seq,
  output logic        o_idle_inserted
);

  localparam logic [63:0] IDLE_TXD = 64'h0000_0000_0000_001E;
  localparam logic [1:0]  IDLE_TXH = 2'b10;
  localparam int unsigned CW       = $clog2(INIT_CYCLES + 1);
  // The WAIT->INIT edge is itself the first ready cycle, so INIT exits when
  // its counter has seen INIT_CYCLES-2 further ready cycles.
  localparam logic [CW-1:0] INIT_LAST = CW'((INIT_CYCLES >= 2) ? (INIT_CYCLES - 2) : 0);
  localparam logic [5:0]    SEQ_LAST  = 6'(SEQ_MAX);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] init_cnt;
  logic [5:0]    seq;
  logic          hdr_ok;

  assign hdr_ok      = i_txh[1] ^ i_txh[0];
  assign o_tx_ready  = (state == ST_RUN) && (seq != SEQ_LAST);
  assign o_init_done = (state == ST_RUN);

  // State register
  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_WAIT;
    else            state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_WAIT: if (i_phy_ready) state_nxt = (INIT_CYCLES <= 1) ? ST_RUN : ST_INIT;
      ST_INIT: begin
        if (!i_phy_ready)              state_nxt = ST_WAIT;
        else if (init_cnt == INIT_LAST) state_nxt = ST_RUN;
      end
      ST_RUN:  if (!i_phy_ready) state_nxt = ST_WAIT;
      default: state_nxt = ST_WAIT;
    endcase
  end

  // Initialisation counter: counts consecutive ready cycles while staying in INIT
  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n)                                   init_cnt <= '0;
    else if (state == ST_INIT && state_nxt == ST_INIT) init_cnt <= init_cnt + 1'b1;
    else                                              init_cnt <= '0;
  end

  // Gearbox sequence counter: free-running in RUN, zero on entry and elsewhere
  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n)                                 seq <= '0;
    else if (state == ST_RUN && state_nxt == ST_RUN) seq <= (seq == SEQ_LAST) ? '0 : seq + 1'b1;
    else                                            seq <= '0;
  end

  // Output block register: accept, idle insertion, or hold on the pause cycle
  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_txd           <= IDLE_TXD;
      o_txh           <= IDLE_TXH;
      o_tx_pause      <= 1'b0;
      o_gearbox_seq   <= '0;
      o_idle_inserted <= 1'b0;
    end else if (state == ST_RUN && i_phy_ready) begin
      o_gearbox_seq <= seq;
      if (seq == SEQ_LAST) begin
        o_tx_pause      <= 1'b1;
        o_idle_inserted <= 1'b0;
      end else if (i_tx_valid && hdr_ok) begin
        o_txd           <= i_txd;
        o_txh           <= i_txh;
        o_tx_pause      <= 1'b0;
        o_idle_inserted <= 1'b0;
      end else begin
        o_txd           <= IDLE_TXD;
        o_txh           <= IDLE_TXH;
        o_tx_pause      <= 1'b0;
        o_idle_inserted <= 1'b1;
      end
    end else begin
      o_txd           <= IDLE_TXD;
      o_txh           <= IDLE_TXH;
      o_tx_pause      <= 1'b0;
      o_gearbox_seq   <= '0;
      o_idle_inserted <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tx_pcs_sequencer.sv
// Directed bench for tx_pcs_sequencer with default parameters (33-cycle
// cadence, 64-cycle initialisation).
module tb_tx_pcs_sequencer;

  localparam logic [63:0] IDLE_TXD = 64'h0000_0000_0000_001E;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        phy_ready;
  logic        tx_valid;
  logic [63:0] txd_in;
  logic [1:0]  txh_in;
  logic        tx_ready;
  logic [63:0] txd_out;
  logic [1:0]  txh_out;
  logic        init_done;
  logic        tx_pause;
  logic [5:0]  gearbox_seq;
  logic        idle_inserted;

  int tests = 0;
  int fails = 0;
  int k     = 0;

  logic [63:0] exp_txd;
  logic [1:0]  exp_txh;
  logic        exp_idle;
  logic        exp_pause;

  tx_pcs_sequencer #(.SEQ_MAX(32), .INIT_CYCLES(64)) dut (
    .i_txc          (clk),
    .i_reset_n      (rst_n),
    .i_phy_ready    (phy_ready),
    .i_tx_valid     (tx_valid),
    .i_txd          (txd_in),
    .i_txh          (txh_in),
    .o_tx_ready     (tx_ready),
    .o_txd          (txd_out),
    .o_txh          (txh_out),
    .o_init_done    (init_done),
    .o_tx_pause     (tx_pause),
    .o_gearbox_seq  (gearbox_seq),
    .o_idle_inserted(idle_inserted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txd"},   txd_out, IDLE_TXD);
    chk({tag, "_txh"},   64'(txh_out), 64'h2);
    chk({tag, "_init"},  64'(init_done), 64'h0);
    chk({tag, "_pause"}, 64'(tx_pause), 64'h0);
    chk({tag, "_seq"},   64'(gearbox_seq), 64'h0);
    chk({tag, "_ready"}, 64'(tx_ready), 64'h0);
    chk({tag, "_idle"},  64'(idle_inserted), 64'h0);
  endtask

  // With i_phy_ready held from WAIT: 63 edges still not initialised, RUN on the 64th
  task automatic wait_init(input string tag);
    for (int i = 0; i < 63; i++) begin
      step();
      chk({tag, "_pre_init"}, 64'(init_done), 64'h0);
      chk({tag, "_pre_txd"},  txd_out, IDLE_TXD);
      chk({tag, "_pre_rdy"},  64'(tx_ready), 64'h0);
    end
    step();
    chk({tag, "_init_rise"}, 64'(init_done), 64'h1);
    chk({tag, "_rdy_rise"},  64'(tx_ready), 64'h1);
    chk({tag, "_seq_rise"},  64'(gearbox_seq), 64'h0);
    chk({tag, "_txd_rise"},  txd_out, IDLE_TXD);
    k = 0;
  endtask

  // Advance n RUN cycles; k is the sequence value presented in the current cycle
  task automatic run(input int n, input bit incr);
    for (int i = 0; i < n; i++) begin
      bit acc;
      acc = ((k % 33) != 32);
      step();
      if (acc) begin
        if (tx_valid && (txh_in == 2'b01 || txh_in == 2'b10)) begin
          exp_txd  = txd_in;
          exp_txh  = txh_in;
          exp_idle = 1'b0;
          if (incr) txd_in = txd_in + 64'd1;
        end else begin
          exp_txd  = IDLE_TXD;
          exp_txh  = 2'b10;
          exp_idle = 1'b1;
        end
      end else begin
        exp_idle = 1'b0;
      end
      exp_pause = !acc;
      chk("run_seq",   64'(gearbox_seq), 64'(k % 33));
      k++;
      chk("run_txd",   txd_out, exp_txd);
      chk("run_txh",   64'(txh_out), 64'(exp_txh));
      chk("run_pause", 64'(tx_pause), 64'(exp_pause));
      chk("run_idle",  64'(idle_inserted), 64'(exp_idle));
      chk("run_ready", 64'(tx_ready), 64'((k % 33) != 32));
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    phy_ready = 1'b0;
    tx_valid  = 1'b0;
    txd_in    = '0;
    txh_in    = 2'b01;
    exp_txd   = IDLE_TXD;
    exp_txh   = 2'b10;
    #2 rst_n = 1'b0;
    #10;
    chk_reset_vals("reset");

    // Release between edges, then hold ready
    step();
    rst_n     = 1'b1;
    phy_ready = 1'b1;
    wait_init("boot");

    // Back-to-back stream with incrementing payload for 330 cycles
    tx_valid = 1'b1;
    txd_in   = 64'hA000_0000_0000_0000;
    txh_in   = 2'b01;
    run(330, 1'b1);

    // Illegal header accepted -> replaced by idle
    txh_in = 2'b11;
    run(1, 1'b1);
    chk("badhdr_idle", 64'(idle_inserted), 64'h1);
    chk("badhdr_txd",  txd_out, IDLE_TXD);
    txh_in = 2'b10;
    run(5, 1'b1);

    // Encoder silent: idles 32 of 33 cycles
    tx_valid = 1'b0;
    run(66, 1'b0);

    // Drop ready while seq=17
    run(11, 1'b0);
    chk("pre_drop_seq", 64'(k % 33), 64'd17);
    phy_ready = 1'b0;
    step();
    chk_reset_vals("run_drop");
    phy_ready = 1'b1;
    wait_init("rerun");
    tx_valid = 1'b1;
    txh_in   = 2'b01;
    run(4, 1'b1);

    // Interrupt initialisation at init_cnt=40
    phy_ready = 1'b0;
    step();
    chk("to_wait_init", 64'(init_done), 64'h0);
    phy_ready = 1'b1;
    for (int i = 0; i < 41; i++) begin
      step();
      chk("partial_init", 64'(init_done), 64'h0);
    end
    phy_ready = 1'b0;
    step();
    chk("abort_init", 64'(init_done), 64'h0);
    phy_ready = 1'b1;
    wait_init("restart");
    run(6, 1'b1);

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
